tanh_simd_scheduler: RTL



---
 rtl/tanh_simd_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/tanh_simd_scheduler.sv
// tanh_simd_scheduler: round-robin packs up to two requester samples per cycle onto a
// shared dual-lane tanh datapath and routes each result back to its issuing requester.
module tanh_simd_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0]         dp_x0,
    output logic [DATA_W-1:0]         dp_x1,
    output logic                      dp_valid_in,
    input  logic [DATA_W-1:0]         dp_y0,
    input  logic [DATA_W-1:0]         dp_y1,
    input  logic                      dp_valid_out,
    output logic                      busy,
    output logic                      err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic          v;
        logic          u0;
        logic [IW-1:0] id0;
        logic          u1;
        logic [IW-1:0] id1;
    } tag_t;

    // tag[0] is loaded alongside dp_valid_in; tag[PIPE_LAT] lines up with dp_valid_out
    tag_t          tag [PIPE_LAT+1];
    tag_t          tl;
    logic [IW-1:0] rr_ptr, g0, g1;
    logic          have0, have1;

    function automatic logic [IW-1:0] wrap(input logic [IW:0] s);
        return (s >= (IW+1)'(NUM_REQ)) ? IW'(s - (IW+1)'(NUM_REQ)) : s[IW-1:0];
    endfunction

    always_comb begin
        have0 = 1'b0;
        have1 = 1'b0;
        g0 = '0;
        g1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [IW-1:0] k;
            k = wrap((IW+1)'(rr_ptr) + (IW+1)'(i));
            if (en && !rst && req_valid[k] && !have1) begin
                if (have0) begin
                    g1 = k;
                    have1 = 1'b1;
                end else begin
                    g0 = k;
                    have0 = 1'b1;
                end
            end
        end
    end

    assign req_ready = (NUM_REQ'(have0) << g0) | (NUM_REQ'(have1) << g1);
    assign tl = tag[PIPE_LAT];

    always_comb begin
        busy = |rsp_valid;
        for (int i = 0; i <= PIPE_LAT; i++)
            busy = busy | tag[i].v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            dp_x0       <= '0;
            dp_x1       <= '0;
            dp_valid_in <= 1'b0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            err         <= 1'b0;
            for (int i = 0; i <= PIPE_LAT; i++)
                tag[i] <= '0;
        end else begin
            rr_ptr      <= have1 ? wrap({1'b0, g1} + (IW+1)'(1)) :
                           have0 ? wrap({1'b0, g0} + (IW+1)'(1)) : rr_ptr;
            dp_valid_in <= have0;
            if (have0) begin
                dp_x0 <= req_data[g0*DATA_W +: DATA_W];
                dp_x1 <= have1 ? req_data[g1*DATA_W +: DATA_W] : '0;
            end
            tag[0] <= '{v: have0, u0: have0, id0: g0, u1: have1, id1: g1};
            for (int i = 1; i <= PIPE_LAT; i++)
                tag[i] <= tag[i-1];
            rsp_valid <= '0;
            // only a valid result matched by a live tag is returned; unused lane 1 is dropped
            if (dp_valid_out && tl.v) begin
                if (tl.u0) begin
                    rsp_valid[tl.id0]                  <= 1'b1;
                    rsp_data[tl.id0*DATA_W +: DATA_W] <= dp_y0;
                end
                if (tl.u1) begin
                    rsp_valid[tl.id1]                  <= 1'b1;
                    rsp_data[tl.id1*DATA_W +: DATA_W] <= dp_y1;
                end
            end
            err <= err | (dp_valid_out != tl.v) | (dp_valid_out & ~tl.u0);
        end
    end
endmodule
